alu_ctrl: RTL and testbench



---
 rtl/alu_ctrl_pkg.sv | 29 ++
 rtl/alu_ctrl_stage.sv | 29 ++
 rtl/alu_ctrl.sv | 92 +++++++++
 tb/tb_alu_ctrl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared types and op encoding for the ALU front-end (alu_ctrl).
package alu_ctrl_pkg;
    localparam int DATA_W = 32;
    localparam int OP_W   = 3;

    localparam logic [OP_W-1:0] OP_ADD  = 3'd0;
    localparam logic [OP_W-1:0] OP_SUB  = 3'd1;
    localparam logic [OP_W-1:0] OP_AND  = 3'd2;
    localparam logic [OP_W-1:0] OP_OR   = 3'd3;
    localparam logic [OP_W-1:0] OP_SRL  = 3'd4;
    localparam logic [OP_W-1:0] OP_SRA  = 3'd5;
    localparam logic [OP_W-1:0] OP_LAST = OP_SRA;

    typedef struct packed {
        logic              illegal;
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } issue_t;

    typedef struct packed {
        logic              err;
        logic [DATA_W-1:0] data;
    } rsp_t;

    function automatic logic is_illegal_op(input logic [OP_W-1:0] op);
        return op > OP_LAST;
    endfunction
endpackage

// File: rtl/alu_ctrl_stage.sv
// Generic register slice: a valid bit plus payload, with load (wins) and clear.
module alu_ctrl_stage #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load_i,
    input  logic         clear_i,
    input  logic [W-1:0] d_i,
    output logic         valid_o,
    output logic [W-1:0] q_o
);
    logic         valid_q;
    logic [W-1:0] data_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            if (load_i)       valid_q <= 1'b1;
            else if (clear_i) valid_q <= 1'b0;
            if (load_i)       data_q  <= d_i;
        end
    end

    assign valid_o = valid_q;
    assign q_o     = data_q;
endmodule

// File: rtl/alu_ctrl.sv
// Two-stage valid/ready front-end for the external combinational ALU.
// Optional ALU_CTRL_SHAMT_MASK_EN: shift ops load only req_b[4:0] as amount.
module alu_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [OP_W-1:0]   req_op,
    input  logic [DATA_W-1:0] req_a,
    input  logic [DATA_W-1:0] req_b,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_op,
    input  logic [DATA_W-1:0] alu_c,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic [CNT_W-1:0]  done_cnt
);
    issue_t issue_d, issue_q;
    rsp_t   rsp_d, rsp_q;
    logic   issue_vld, rsp_vld;
    logic   req_fire, rsp_fire, adv;
    logic [CNT_W-1:0] done_cnt_d, done_cnt_q;

    assign rsp_fire  = rsp_vld && rsp_ready;
    assign adv       = issue_vld && (!rsp_vld || rsp_fire);
    // Gated by reset_n so no request is taken while the stages are held clear.
    assign req_ready = reset_n && (!issue_vld || adv);
    assign req_fire  = req_valid && req_ready;

    always_comb begin
        issue_d = '0;
        if (is_illegal_op(req_op)) begin
            issue_d.illegal = 1'b1;
        end else begin
            issue_d.op = req_op;
            issue_d.a  = req_a;
            issue_d.b  = req_b;
`ifdef ALU_CTRL_SHAMT_MASK_EN
            if (req_op == OP_SRL || req_op == OP_SRA)
                issue_d.b = {{(DATA_W-5){1'b0}}, req_b[4:0]};
`endif
        end
    end

    always_comb begin
        rsp_d      = '0;
        rsp_d.err  = issue_q.illegal;
        rsp_d.data = issue_q.illegal ? '0 : alu_c;
    end

    alu_ctrl_stage #(.W($bits(issue_t))) u_issue (
        .clk     (clk),
        .reset_n (reset_n),
        .load_i  (req_fire),
        .clear_i (adv),
        .d_i     (issue_d),
        .valid_o (issue_vld),
        .q_o     (issue_q)
    );

    alu_ctrl_stage #(.W($bits(rsp_t))) u_rsp (
        .clk     (clk),
        .reset_n (reset_n),
        .load_i  (adv),
        .clear_i (rsp_fire),
        .d_i     (rsp_d),
        .valid_o (rsp_vld),
        .q_o     (rsp_q)
    );

    assign done_cnt_d = rsp_fire ? done_cnt_q + 1'b1 : done_cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) done_cnt_q <= '0;
        else          done_cnt_q <= done_cnt_d;
    end

    assign alu_a     = issue_q.a;
    assign alu_b     = issue_q.b;
    assign alu_op    = issue_q.op;
    assign rsp_valid = rsp_vld;
    assign rsp_data  = rsp_q.data;
    assign rsp_err   = rsp_q.err;
    assign done_cnt  = done_cnt_q;
endmodule

// File: tb/tb_alu_ctrl.sv
// Randomized + directed bench for alu_ctrl against a FIFO-level reference model.
module tb_alu_ctrl;
    localparam int CNT_W = 4;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              req_valid, req_ready, rsp_valid, rsp_ready, rsp_err;
    logic [2:0]        req_op, alu_op;
    logic [31:0]       req_a, req_b, alu_a, alu_b, alu_c, rsp_data;
    logic [CNT_W-1:0]  done_cnt;

    typedef struct {
        logic [32:0] res;
        int          acc;
    } ent_t;

    ent_t q[$];
    int   checks = 0, failures = 0, cyc = 0, done_m = 0;

    always #5 clk = ~clk;

    alu_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_c(alu_c),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_err(rsp_err), .done_cnt(done_cnt)
    );

    // External combinational ALU
    always_comb begin
        alu_c = '0;
        case (alu_op)
            3'd0: alu_c = alu_a + alu_b;
            3'd1: alu_c = alu_a - alu_b;
            3'd2: alu_c = alu_a & alu_b;
            3'd3: alu_c = alu_a | alu_b;
            3'd4: alu_c = alu_a >> alu_b;
            3'd5: alu_c = $signed(alu_a) >>> alu_b;
            default: alu_c = '0;
        endcase
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [32:0] ref_res(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [31:0] sh;
        sh = b;
`ifdef ALU_CTRL_SHAMT_MASK_EN
        if (op == 3'd4 || op == 3'd5) sh = b & 32'h1f;
`endif
        case (op)
            3'd0: return {1'b0, a + b};
            3'd1: return {1'b0, a - b};
            3'd2: return {1'b0, a & b};
            3'd3: return {1'b0, a | b};
            3'd4: return {1'b0, a >> sh};
            3'd5: return {1'b0, 32'($signed(a) >>> sh)};
            default: return {1'b1, 32'h0};
        endcase
    endfunction

    // One clock of stimulus: drive at negedge, check, then advance the model at posedge.
    task automatic step(input logic v, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic rr);
        logic exp_rv, exp_rr, fire_req, fire_rsp;
        logic [CNT_W-1:0] exp_cnt;
        @(negedge clk);
        req_valid = v; req_op = op; req_a = a; req_b = b; rsp_ready = rr;
        #1;
        exp_rv  = (q.size() > 0) && (q[0].acc < cyc);
        exp_rr  = (q.size() < 2) || rr;
        exp_cnt = CNT_W'(done_m);
        chk("req_ready", req_ready, exp_rr);
        chk("rsp_valid", rsp_valid, exp_rv);
        if (exp_rv && rsp_valid) begin
            chk("rsp_data", rsp_data, q[0].res[31:0]);
            chk("rsp_err", rsp_err, q[0].res[32]);
        end
        chk("done_cnt", done_cnt, exp_cnt);
        fire_req = v && exp_rr;
        fire_rsp = exp_rv && rr;
        @(posedge clk);
        cyc++;
        if (fire_rsp) begin
            void'(q.pop_front());
            done_m++;
        end
        if (fire_req) q.push_back('{ref_res(op, a, b), cyc});
    endtask

    task automatic idle(input logic rr);
        step(1'b0, 3'd0, 32'h0, 32'h0, rr);
    endtask

    initial begin
        reset_n = 1'b0; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
        #12;
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_b", alu_b, 0);
        chk("rst_alu_op", alu_op, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_done_cnt", done_cnt, 0);
        chk("rst_req_ready", req_ready, 0);
        @(negedge clk); reset_n = 1'b1; #1;
        chk("post_rst_ready", req_ready, 1);

        // add/sub back to back
        step(1'b1, 3'd0, 32'd5, 32'd7, 1'b1);
        step(1'b1, 3'd1, 32'd0, 32'd1, 1'b1);
        #1; chk("add_5_7", rsp_data, 32'd12);
        idle(1'b1);
        #1; chk("sub_0_1", rsp_data, 32'hFFFF_FFFF); chk("sub_err", rsp_err, 0);
        idle(1'b1);

        // backpressure: two buffered, third refused
        step(1'b1, 3'd0, 32'd1, 32'd1, 1'b0);
        step(1'b1, 3'd0, 32'd2, 32'd2, 1'b0);
        step(1'b1, 3'd0, 32'd3, 32'd3, 1'b0);
        #1; chk("bp_full_ready", req_ready, 0); chk("bp_hold_data", rsp_data, 32'd2);
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);
        #1; chk("bp_done_cnt", done_cnt, 4'd4);

        // illegal op then and
        step(1'b1, 3'd6, 32'h1234, 32'h55, 1'b1);
        step(1'b1, 3'd2, 32'hF0, 32'h3C, 1'b1);
        #1; chk("ill_data", rsp_data, 0); chk("ill_err", rsp_err, 1);
        idle(1'b1);
        #1; chk("and_data", rsp_data, 32'h30); chk("and_err", rsp_err, 0);
        idle(1'b1);

        // shifts
        step(1'b1, 3'd5, 32'h8000_0000, 32'd4, 1'b1);
        step(1'b1, 3'd4, 32'h100, 32'd33, 1'b1);
        #1; chk("sra_4", rsp_data, 32'hF800_0000);
        idle(1'b1);
`ifdef ALU_CTRL_SHAMT_MASK_EN
        #1; chk("srl_33", rsp_data, 32'h80);
`else
        #1; chk("srl_33", rsp_data, 32'h0);
`endif
        idle(1'b1);

        // reset with two ops in flight
        step(1'b1, 3'd0, 32'd10, 32'd20, 1'b0);
        step(1'b1, 3'd3, 32'd1, 32'd2, 1'b0);
        @(negedge clk);
        req_valid = 1'b1; reset_n = 1'b0;
        #1;
        chk("mid_rst_ready", req_ready, 0);
        chk("mid_rst_valid", rsp_valid, 0);
        chk("mid_rst_data", rsp_data, 0);
        chk("mid_rst_alu_a", alu_a, 0);
        chk("mid_rst_alu_op", alu_op, 0);
        chk("mid_rst_cnt", done_cnt, 0);
        q.delete();
        done_m = 0;
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1; req_valid = 1'b0; rsp_ready = 1'b1;
        #1;
        chk("rel_ready", req_ready, 1);
        chk("rel_valid", rsp_valid, 0);
        chk("rel_cnt", done_cnt, 0);
        idle(1'b1);
        idle(1'b1);

        // counter wrap: 17 consumed responses
        for (int i = 0; i < 17; i++)
            step(1'b1, 3'($urandom_range(0, 7)), $urandom, $urandom, 1'b1);
        idle(1'b1);
        idle(1'b1);
        #1; chk("cnt_wrap", done_cnt, 4'd1);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            logic [31:0] b;
            b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            step(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), $urandom, b,
                 1'($urandom_range(0, 2) != 0));
        end
        for (int i = 0; i < 4; i++) idle(1'b1);
        #1; chk("final_cnt", done_cnt, CNT_W'(done_m));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
